imem_loader: RTL
================

IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 Parameter: ADDR_W, default 10, byte-address width of the target instruction memory.
REQ-002 Parameter: CNT_W, default 9, width of the word_count input (maximum 256 words).
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 reset  input  1  reset, asynchronous, active-high.
REQ-005 start  input  1  single-cycle request to begin a load; sampled only in IDLE.
REQ-006 base_addr  input  ADDR_W  first byte address written; captured on the start cycle.
REQ-007 word_count  input  CNT_W  number of 32-bit words to load; captured on the start cycle.
REQ-008 in_valid  input  1  source has a word on in_data.
REQ-009 in_data  input  32  instruction word, little-endian byte order.
REQ-010 in_ready  output  1  loader accepts in_data this cycle.
REQ-011 mem_we  output  1  byte write strobe to the instruction memory.
REQ-012 mem_addr  output  ADDR_W  byte address for the current write.
REQ-013 mem_wdata  output  8  byte written.
REQ-014 busy  output  1  a load is in progress.
REQ-015 cpu_hold  output  1  holds the core in reset while high.
REQ-016 done  output  1  one-cycle pulse when a load completes.
REQ-017 wrap_err  output  1  sticky flag: a write address wrapped past 2^ADDR_W-1.

Function
REQ-018 The FSM SHALL have states IDLE, ACCEPT, WRITE, and DONE.
REQ-019 IDLE: when start=1, capture base_addr and word_count and clear wrap_err; go to DONE if word_count=0, otherwise go to ACCEPT.
REQ-020 ACCEPT: in_ready=1; on in_valid&in_ready, latch in_data, set byte index to 0, and go to WRITE; otherwise stay in ACCEPT with no timeout.
REQ-021 WRITE: mem_we=1 for exactly 4 consecutive cycles with mem_wdata = latched word byte[i] (i=0..3, bits 8i+7:8i) and mem_addr = current address.
REQ-022 In WRITE, the address SHALL increment by 1 after each byte.
REQ-023 After byte 3, decrement the remaining count and go to DONE if it reaches 0, otherwise go to ACCEPT.
REQ-024 in_ready SHALL be 0 in every state except ACCEPT, so throughput is 1 word per 5 cycles when in_valid is held high.
REQ-025 DONE: done=1 for exactly one cycle, then go to IDLE.
REQ-026 busy and cpu_hold SHALL be registered and high in ACCEPT, WRITE and DONE; both SHALL fall on the cycle after DONE.
REQ-027 Address arithmetic SHALL be modulo 2^ADDR_W: 1023+1 gives 0.
REQ-028 Any increment that wraps the address to 0 SHALL set wrap_err, which then holds until the next accepted start or reset.
REQ-029 start SHALL be ignored outside IDLE; captured parameters SHALL NOT change mid-load.
REQ-030 mem_we SHALL be 0 in IDLE, ACCEPT and DONE.
REQ-031 mem_addr and mem_wdata are don't-care when mem_we=0 but SHALL be driven from registers with no combinational path from in_data.
REQ-032 Latency from the accepting handshake to the first mem_we SHALL be 1 cycle.

Reset
REQ-033 On reset=1, the block SHALL immediately enter IDLE and drive in_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, busy=0, cpu_hold=0, done=0 and wrap_err=0.
REQ-034 A reset during ACCEPT or WRITE SHALL abort the load with no done pulse; bytes already written remain in memory.
REQ-035 Deassertion of reset SHALL NOT by itself start a load.

Structure
REQ-036 The shared package SHALL hold the state enum (IDLE, ACCEPT, WRITE, DONE), the ADDR_W default of 10, and the byte-lanes-per-word constant of 4.
REQ-037 imem_loader SHALL be a single module with no sub-modules; the byte-lane mux and the counters SHALL be inline.

Verification
REQ-038 base_addr=0, word_count=2, words 0x00500093 and 0x00A00113 with in_valid held high -> writes 93,00,50,00 at addresses 0..3 and 13,01,A0,00 at addresses 4..7; done pulses 11 cycles after start; a word read back at address 0 = 0x00500093.
REQ-039 word_count=0 -> no mem_we, done pulses on the cycle after start, busy high for 1 cycle.
REQ-040 base_addr=1022, word_count=1, word 0xDEADBEEF -> EF@1022, BE@1023, AD@0, DE@1; wrap_err=1 after the load and cleared by the next start.
REQ-041 Load of 3 words with in_valid low for 6 cycles before the 2nd word -> loader stalls in ACCEPT with in_ready=1 and no writes, then resumes with the correct addresses; done pulses exactly once.
REQ-042 reset asserted during byte 2 of word 1 of a 4-word load -> all outputs 0 in the same cycle; no done pulse; a subsequent start performs a full, correct load.
REQ-043 start pulsed while busy with a different base_addr -> ignored; the original load completes unchanged.

Source files
------------

// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory loader: FSM states and
// word/byte geometry constants.
package imem_loader_pkg;

   // Default byte-address width of the target instruction memory.
   localparam int unsigned ADDR_W_DEFAULT = 10;

   // Byte lanes per 32-bit instruction word.
   localparam int unsigned LANES_PER_WORD = 4;

   typedef enum logic [1:0] {
      StIdle,
      StAccept,
      StWrite,
      StDone
   } state_e;

endpackage

// File: rtl/imem_loader.sv
// Instruction-memory loader: accepts 32-bit words over a valid/ready stream
// and writes each word as four little-endian bytes at consecutive addresses,
// holding the core in reset for the duration of the load.
module imem_loader
   import imem_loader_pkg::*;
#(
   parameter int unsigned ADDR_W = ADDR_W_DEFAULT,
   parameter int unsigned CNT_W  = 9
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic [CNT_W-1:0]  word_count,
   input  logic              in_valid,
   input  logic [31:0]       in_data,
   output logic              in_ready,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [7:0]        mem_wdata,
   output logic              busy,
   output logic              cpu_hold,
   output logic              done,
   output logic              wrap_err
);

   localparam logic [1:0] LAST_LANE = 2'(LANES_PER_WORD - 1);

   state_e            state_q;
   logic [31:0]       word_q;
   logic [ADDR_W-1:0] addr_q;
   logic [ADDR_W-1:0] addr_nxt;
   logic [CNT_W-1:0]  cnt_q;
   logic [1:0]        lane_q;
   logic [1:0]        lane_nxt;

   // addr_q is the address of the byte currently presented on mem_addr
   // (or the next byte to write while waiting for a word).
   assign addr_nxt = addr_q + ADDR_W'(1);
   assign lane_nxt = lane_q + 2'd1;

   // Load sequencer; every output is a register updated on state transitions.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= StIdle;
         word_q    <= '0;
         addr_q    <= '0;
         cnt_q     <= '0;
         lane_q    <= '0;
         in_ready  <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         busy      <= 1'b0;
         cpu_hold  <= 1'b0;
         done      <= 1'b0;
         wrap_err  <= 1'b0;
      end else begin
         done <= 1'b0;
         unique case (state_q)
            StIdle: begin
               if (start) begin
                  addr_q   <= base_addr;
                  cnt_q    <= word_count;
                  wrap_err <= 1'b0;
                  busy     <= 1'b1;
                  cpu_hold <= 1'b1;
                  if (word_count == '0) begin
                     state_q <= StDone;
                     done    <= 1'b1;
                  end else begin
                     state_q  <= StAccept;
                     in_ready <= 1'b1;
                  end
               end
            end
            StAccept: begin
               // Byte 0 goes out on the cycle right after the handshake.
               if (in_valid && in_ready) begin
                  word_q    <= in_data;
                  lane_q    <= '0;
                  in_ready  <= 1'b0;
                  mem_we    <= 1'b1;
                  mem_addr  <= addr_q;
                  mem_wdata <= in_data[7:0];
                  state_q   <= StWrite;
               end
            end
            StWrite: begin
               // Address advances after every byte, including the last of a word.
               addr_q <= addr_nxt;
               if (addr_nxt == '0) begin
                  wrap_err <= 1'b1;
               end
               if (lane_q == LAST_LANE) begin
                  mem_we <= 1'b0;
                  cnt_q  <= cnt_q - CNT_W'(1);
                  if (cnt_q == CNT_W'(1)) begin
                     state_q <= StDone;
                     done    <= 1'b1;
                  end else begin
                     state_q  <= StAccept;
                     in_ready <= 1'b1;
                  end
               end else begin
                  lane_q    <= lane_nxt;
                  mem_addr  <= addr_nxt;
                  mem_wdata <= word_q[{lane_nxt, 3'b000} +: 8];
               end
            end
            StDone: begin
               busy     <= 1'b0;
               cpu_hold <= 1'b0;
               state_q  <= StIdle;
            end
            default: begin
               state_q <= StIdle;
            end
         endcase
      end
   end

endmodule
